// File: rtl/fpu_pkg.sv
// Shared binary32 FPU definitions: FSM state encodings, format constants and the
// unpacked-operand type used by both the divider and the multiplier.
package fpu_pkg;

    typedef enum logic [3:0] {
        get_a, get_b, unpack, special_cases, normalise_a, normalise_b,
        divide_0, divide_1, divide_2, normalise_1, normalise_2, round, pack, put_z
    } fpu_state_t;

    localparam logic        [9:0]  EXP_BIAS    = 10'd127;
    localparam logic signed [9:0]  EXP_MIN     = -10'sd126;
    localparam logic signed [9:0]  EXP_MAX     = 10'sd127;
    localparam logic signed [9:0]  EXP_ZERO    = -10'sd127;  // field 0: zero or denormal
    localparam logic signed [9:0]  EXP_SPECIAL = 10'sd128;   // field 255: inf or NaN
    localparam logic        [31:0] QNAN        = 32'hFFC00000;
    localparam logic        [7:0]  INF_EXP     = 8'hFF;

    typedef struct packed {
        logic              s;
        logic signed [9:0] e;
        logic [23:0]       m;
    } fpu_operand_t;

    // Fraction only; the hidden bit is restored once specials are ruled out.
    function automatic fpu_operand_t unpack_op(input logic [31:0] x);
        fpu_operand_t o;
        o.s = x[31];
        o.e = $signed({2'b00, x[30:23]} - EXP_BIAS);
        o.m = {1'b0, x[22:0]};
        return o;
    endfunction

endpackage

// File: rtl/divider.sv
// Binary32 divider z = a / b: strobe/ack operand handshake, restoring divide
// (one quotient bit per cycle), normalise, round-to-nearest-even and pack.
module divider
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    fpu_state_t        state, state_next;
    logic [31:0]       a, b, z;
    fpu_operand_t      op_a, op_b;
    logic              z_s;
    logic signed [9:0] z_e;
    logic [23:0]       z_m;
    logic              guard, round_bit, sticky;
    logic [49:0]       dividend, quotient;
    logic [23:0]       divisor;
    logic [24:0]       remainder;
    logic [5:0]        count;
    logic              a_ack_next, b_ack_next, z_stb_next;

    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic              sign_xor;
    logic [31:0]       special_z;
    logic [24:0]       rem_shift;
    logic              rem_ge;
    logic [24:0]       m_round;

    assign sign_xor  = op_a.s ^ op_b.s;
    assign rem_shift = {remainder[23:0], dividend[49]};
    assign rem_ge    = rem_shift >= {1'b0, divisor};
    assign m_round   = {1'b0, z_m} + 25'd1;

    always_comb begin
        a_nan  = (op_a.e == EXP_SPECIAL) && (op_a.m != '0);
        b_nan  = (op_b.e == EXP_SPECIAL) && (op_b.m != '0);
        a_inf  = (op_a.e == EXP_SPECIAL) && (op_a.m == '0);
        b_inf  = (op_b.e == EXP_SPECIAL) && (op_b.m == '0);
        a_zero = (op_a.e == EXP_ZERO) && (op_a.m == '0);
        b_zero = (op_b.e == EXP_ZERO) && (op_b.m == '0);
        special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        // Priority order matters: NaN beats inf/inf beats inf beats zero.
        if (a_nan || b_nan)       special_z = QNAN;
        else if (a_inf && b_inf)  special_z = QNAN;
        else if (a_inf)           special_z = {sign_xor, INF_EXP, 23'd0};
        else if (b_inf)           special_z = {sign_xor, 31'd0};
        else if (b_zero)          special_z = a_zero ? QNAN : {sign_xor, INF_EXP, 23'd0};
        else                      special_z = {sign_xor, 31'd0};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= get_a;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            get_a:         if (input_a_ack && input_a_stb) state_next = get_b;
            get_b:         if (input_b_ack && input_b_stb) state_next = unpack;
            unpack:        state_next = special_cases;
            special_cases: state_next = special ? put_z : normalise_a;
            normalise_a:   if (op_a.m[23]) state_next = normalise_b;
            normalise_b:   if (op_b.m[23]) state_next = divide_0;
            divide_0:      state_next = divide_1;
            divide_1:      if (count == 6'd49) state_next = divide_2;
            divide_2:      state_next = normalise_1;
            normalise_1:   if (z_m[23]) state_next = normalise_2;
            normalise_2:   if (!(z_e < EXP_MIN)) state_next = round;
            round:         state_next = pack;
            pack:          state_next = put_z;
            put_z:         if (output_z_stb && output_z_ack) state_next = get_a;
            default:       state_next = get_a;
        endcase
    end

    always_comb begin
        a_ack_next = (state == get_a) && !(input_a_ack && input_a_stb);
        b_ack_next = (state == get_b) && !(input_b_ack && input_b_stb);
        z_stb_next = (state == put_z) && !(output_z_stb && output_z_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
        end else begin
            input_a_ack  <= a_ack_next;
            input_b_ack  <= b_ack_next;
            output_z_stb <= z_stb_next;
            case (state)
                get_a: if (input_a_ack && input_a_stb) a <= input_a;
                get_b: if (input_b_ack && input_b_stb) b <= input_b;
                unpack: begin
                    op_a <= unpack_op(a);
                    op_b <= unpack_op(b);
                end
                special_cases: begin
                    if (special) begin
                        z <= special_z;
                    end else begin
                        if (op_a.e == EXP_ZERO) op_a.e <= EXP_MIN;
                        else                    op_a.m[23] <= 1'b1;
                        if (op_b.e == EXP_ZERO) op_b.e <= EXP_MIN;
                        else                    op_b.m[23] <= 1'b1;
                    end
                end
                normalise_a: if (!op_a.m[23]) begin
                    op_a.m <= op_a.m << 1;
                    op_a.e <= op_a.e - 10'sd1;
                end
                normalise_b: if (!op_b.m[23]) begin
                    op_b.m <= op_b.m << 1;
                    op_b.e <= op_b.e - 10'sd1;
                end
                divide_0: begin
                    z_s       <= sign_xor;
                    z_e       <= op_a.e - op_b.e;
                    dividend  <= {op_a.m, 26'd0};
                    divisor   <= op_b.m;
                    remainder <= '0;
                    quotient  <= '0;
                    count     <= '0;
                end
                divide_1: begin
                    quotient  <= {quotient[48:0], rem_ge};
                    remainder <= rem_ge ? rem_shift - {1'b0, divisor} : rem_shift;
                    dividend  <= dividend << 1;
                    count     <= count + 6'd1;
                end
                divide_2: begin
                    z_m       <= quotient[26:3];
                    guard     <= quotient[2];
                    round_bit <= quotient[1];
                    sticky    <= quotient[0] | (remainder != '0);
                end
                normalise_1: if (!z_m[23]) begin
                    z_m       <= {z_m[22:0], guard};
                    guard     <= round_bit;
                    round_bit <= 1'b0;
                    z_e       <= z_e - 10'sd1;
                end
                // Denormalise: bits shifted out still feed guard/round/sticky.
                normalise_2: if (z_e < EXP_MIN) begin
                    z_m       <= z_m >> 1;
                    guard     <= z_m[0];
                    round_bit <= guard;
                    sticky    <= sticky | round_bit;
                    z_e       <= z_e + 10'sd1;
                end
                round: if (guard && (round_bit | sticky | z_m[0])) begin
                    if (m_round[24]) begin
                        z_m <= 24'h800000;
                        z_e <= z_e + 10'sd1;
                    end else begin
                        z_m <= m_round[23:0];
                    end
                end
                pack: begin
                    z[31]    <= z_s;
                    z[22:0]  <= z_m[22:0];
                    z[30:23] <= z_e[7:0] + EXP_BIAS[7:0];
                    if ((z_e == EXP_MIN) && !z_m[23]) z[30:23] <= 8'd0;
                    if (z_e > EXP_MAX) begin
                        z[30:23] <= INF_EXP;
                        z[22:0]  <= 23'd0;
                    end
                end
                put_z: output_z <= z;
                default: ;
            endcase
        end
    end

endmodule
